// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wn;
        logic [REG_DATA_W-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of write-back requests; exposes storage, valid bits and pointers
// so the owner can run an associative search over pending entries.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  wb_req_t              push_data,
    output wb_req_t [DEPTH-1:0]  entries,
    output logic    [DEPTH-1:0]  valid,
    output logic    [PTR_W-1:0]  wr_ptr,
    output logic    [PTR_W-1:0]  rd_ptr,
    output logic    [CNT_W-1:0]  count
);

    wb_req_t [DEPTH-1:0] entries_q;
    logic    [DEPTH-1:0] valid_q, valid_d;
    logic    [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic    [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_ptr_q] <= push_data;
        end
    end

    assign entries = entries_q;
    assign valid   = valid_q;
    assign wr_ptr  = wr_ptr_q;
    assign rd_ptr  = rd_ptr_q;
    assign count   = count_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port, retiring one entry
// per cycle and forwarding the youngest pending value for two read indices.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_wn,
    input  logic [DATA_W-1:0]            in_wd,
    input  logic                         wb_stall,
    output logic                         rf_RegWrite,
    output logic [ADDR_W-1:0]            rf_wn,
    output logic [DATA_W-1:0]            rf_wd,
    input  logic [ADDR_W-1:0]            rs,
    input  logic [ADDR_W-1:0]            rt,
    output logic                         byp_hit_rs,
    output logic [DATA_W-1:0]            byp_data_rs,
    output logic                         byp_hit_rt,
    output logic [DATA_W-1:0]            byp_data_rt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_req_t              push_req;
    wb_req_t              head;
    wb_req_t [DEPTH-1:0]  entries;
    logic    [DEPTH-1:0]  valid;
    logic    [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic    [PTR_W-1:0]  slot;
    logic                 push, pop;

    // Writes to r0 complete the handshake but are never queued.
    assign in_ready = (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && (in_wn != REG_ZERO);
    assign pop      = rf_RegWrite;

    always_comb begin
        push_req.wn = in_wn;
        push_req.wd = in_wd;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_req),
        .entries   (entries),
        .valid     (valid),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    assign head        = entries[rd_ptr];
    assign rf_RegWrite = (count != '0) && !wb_stall;
    assign rf_wn       = (count != '0) ? head.wn : '0;
    assign rf_wd       = (count != '0) ? head.wd : '0;

    // Walk from wr_ptr (oldest slot when full) round to wr_ptr-1 (youngest);
    // later matches overwrite earlier ones so the youngest wins.
    always_comb begin
        slot        = '0;
        byp_hit_rs  = 1'b0;
        byp_data_rs = '0;
        byp_hit_rt  = 1'b0;
        byp_data_rt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = wr_ptr + PTR_W'(i);
            if (valid[slot]) begin
                if ((rs != REG_ZERO) && (entries[slot].wn == rs)) begin
                    byp_hit_rs  = 1'b1;
                    byp_data_rs = entries[slot].wd;
                end
                if ((rt != REG_ZERO) && (entries[slot].wn == rt)) begin
                    byp_hit_rt  = 1'b1;
                    byp_data_rt = entries[slot].wd;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed and model-checked random bench for regfile_wb_queue.
module tb_regfile_wb_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_wn;
    logic [DATA_W-1:0] in_wd;
    logic              wb_stall;
    logic              rf_RegWrite;
    logic [ADDR_W-1:0] rf_wn;
    logic [DATA_W-1:0] rf_wd;
    logic [ADDR_W-1:0] rs, rt;
    logic              byp_hit_rs, byp_hit_rt;
    logic [DATA_W-1:0] byp_data_rs, byp_data_rt;
    logic [CNT_W-1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+DATA_W-1:0] mq[$];

    always #5 clk = ~clk;

    regfile_wb_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wn       (in_wn),
        .in_wd       (in_wd),
        .wb_stall    (wb_stall),
        .rf_RegWrite (rf_RegWrite),
        .rf_wn       (rf_wn),
        .rf_wd       (rf_wd),
        .rs          (rs),
        .rt          (rt),
        .byp_hit_rs  (byp_hit_rs),
        .byp_data_rs (byp_data_rs),
        .byp_hit_rt  (byp_hit_rt),
        .byp_data_rt (byp_data_rt),
        .count       (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [ADDR_W-1:0] wn, input logic [DATA_W-1:0] wd);
        in_valid = 1'b1;
        in_wn    = wn;
        in_wd    = wd;
        step();
        in_valid = 1'b0;
    endtask

    function automatic void model_byp(input logic [ADDR_W-1:0] idx, output logic hit,
                                      output logic [DATA_W-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (idx != '0) begin
            foreach (mq[k]) begin
                if (mq[k][ADDR_W+DATA_W-1:DATA_W] == idx) begin
                    hit  = 1'b1;
                    data = mq[k][DATA_W-1:0];
                end
            end
        end
    endfunction

    initial begin
        logic [ADDR_W-1:0] exp_wns[4];
        logic [DATA_W-1:0] exp_wds[4];
        logic              e_hit;
        logic [DATA_W-1:0] e_data;
        logic              acc, ret;
        logic [ADDR_W+DATA_W-1:0] hd;

        rst = 1'b1; in_valid = 1'b0; in_wn = '0; in_wd = '0;
        wb_stall = 1'b0; rs = '0; rt = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_regwrite", rf_RegWrite, 0);
        check("rst_wn", rf_wn, 0);
        check("rst_wd", rf_wd, 0);
        check("rst_hit_rs", byp_hit_rs, 0);
        check("rst_data_rt", byp_data_rt, 0);
        check("rst_ready", in_ready, 1);
        check("rst_count", count, 0);

        // Single push, retired the following cycle.
        in_valid = 1'b1; in_wn = 5'd3; in_wd = 32'hDEADBEEF;
        #1;
        check("single_no_passthru", rf_RegWrite, 0);
        step();
        in_valid = 1'b0;
        #1;
        check("single_regwrite", rf_RegWrite, 1);
        check("single_wn", rf_wn, 3);
        check("single_wd", rf_wd, 32'hDEADBEEF);
        check("single_count1", count, 1);
        step();
        check("single_count0", count, 0);
        check("single_idle", rf_RegWrite, 0);

        // Stalled fill, bypass youngest, then in-order drain.
        wb_stall = 1'b1;
        push_one(5'd5, 32'h11);
        push_one(5'd5, 32'h22);
        push_one(5'd7, 32'h33);
        rs = 5'd5; rt = 5'd7;
        #1;
        check("stall_count", count, 3);
        check("stall_regwrite", rf_RegWrite, 0);
        check("byp_rs_hit", byp_hit_rs, 1);
        check("byp_rs_youngest", byp_data_rs, 32'h22);
        check("byp_rt_hit", byp_hit_rt, 1);
        check("byp_rt_data", byp_data_rt, 32'h33);
        wb_stall = 1'b0;
        #1;
        check("drain0_wn", rf_wn, 5);
        check("drain0_wd", rf_wd, 32'h11);
        step();
        check("drain1_wn", rf_wn, 5);
        check("drain1_wd", rf_wd, 32'h22);
        check("drain1_byp_rs", byp_data_rs, 32'h22);
        step();
        check("drain2_wn", rf_wn, 7);
        check("drain2_wd", rf_wd, 32'h33);
        check("drain2_byp_rs_miss", byp_hit_rs, 0);
        step();
        check("drain_done", count, 0);

        // Write to r0 is accepted and dropped.
        in_valid = 1'b1; in_wn = 5'd0; in_wd = 32'hFFFF; rs = 5'd0; rt = 5'd0;
        #1;
        check("r0_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        #1;
        check("r0_count", count, 0);
        check("r0_regwrite", rf_RegWrite, 0);
        check("r0_hit_rs", byp_hit_rs, 0);

        // Full queue back-pressure, then refill behind three survivors.
        wb_stall = 1'b1;
        push_one(5'd1, 32'hA1);
        push_one(5'd2, 32'hA2);
        push_one(5'd3, 32'hA3);
        push_one(5'd4, 32'hA4);
        #1;
        check("full_count", count, 4);
        check("full_ready", in_ready, 0);
        in_valid = 1'b1; in_wn = 5'd9; in_wd = 32'h99;
        step();
        check("full_blocked", count, 4);
        wb_stall = 1'b0;
        #1;
        check("full_pop_wn", rf_wn, 1);
        check("full_pop_ready", in_ready, 0);
        step();
        wb_stall = 1'b1;
        #1;
        check("after_pop_count", count, 3);
        check("after_pop_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        rs = 5'd9; rt = 5'd2;
        #1;
        check("refill_count", count, 4);
        check("refill_byp_rs", byp_data_rs, 32'h99);
        check("refill_byp_rt", byp_data_rt, 32'hA2);
        wb_stall = 1'b0;
        exp_wns = '{5'd2, 5'd3, 5'd4, 5'd9};
        exp_wds = '{32'hA2, 32'hA3, 32'hA4, 32'h99};
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("refill_wn%0d", i), rf_wn, exp_wns[i]);
            check($sformatf("refill_wd%0d", i), rf_wd, exp_wds[i]);
            step();
        end
        check("refill_empty", count, 0);

        // Reset drops pending entries.
        wb_stall = 1'b1;
        push_one(5'd10, 32'hB0);
        push_one(5'd11, 32'hB1);
        push_one(5'd12, 32'hB2);
        #1;
        check("prerst_count", count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0; wb_stall = 1'b0; rs = 5'd10; rt = 5'd12;
        #1;
        check("midrst_count", count, 0);
        check("midrst_regwrite", rf_RegWrite, 0);
        check("midrst_hit_rs", byp_hit_rs, 0);
        check("midrst_hit_rt", byp_hit_rt, 0);
        step();
        check("midrst_no_retire", rf_RegWrite, 0);

        // Random traffic against a reference queue.
        mq.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_wn    = ADDR_W'($urandom_range(0, 7));
            in_wd    = $urandom;
            wb_stall = ($urandom_range(0, 9) < 3);
            rs       = ADDR_W'($urandom_range(0, 7));
            rt       = ADDR_W'($urandom_range(0, 7));
            #1;
            hd = (mq.size() != 0) ? mq[0] : '0;
            check("rnd_count", count, mq.size());
            check("rnd_ready", in_ready, mq.size() < DEPTH);
            check("rnd_regwrite", rf_RegWrite, (mq.size() != 0) && !wb_stall);
            check("rnd_wn", rf_wn, hd[ADDR_W+DATA_W-1:DATA_W]);
            check("rnd_wd", rf_wd, hd[DATA_W-1:0]);
            model_byp(rs, e_hit, e_data);
            check("rnd_hit_rs", byp_hit_rs, e_hit);
            check("rnd_data_rs", byp_data_rs, e_data);
            model_byp(rt, e_hit, e_data);
            check("rnd_hit_rt", byp_hit_rt, e_hit);
            check("rnd_data_rt", byp_data_rt, e_data);
            acc = in_valid && (mq.size() < DEPTH) && (in_wn != '0);
            ret = (mq.size() != 0) && !wb_stall;
            step();
            if (ret) void'(mq.pop_front());
            if (acc) mq.push_back({in_wn, in_wd});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
